// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized sig_in rising edges over fixed GATE_LEN-cycle windows.
// Latency: edge detected 2 clk after sig_in rises; result registered 1 clk after the window's last cycle.
// No backpressure: valid is a single-cycle pulse; windows run back-to-back while enable is high.
module freq_meter #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int GATE_HZ  = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int GATE_LEN = CLK_FREQ / GATE_HZ;
  localparam int GW       = (GATE_LEN < 2) ? 1 : $clog2(GATE_LEN);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_LEN - 1);

  // A window shorter than two cycles cannot hold a single detectable edge.
  if (GATE_LEN < 2) begin : g_bad_gate
    $error("freq_meter: GATE_LEN = CLK_FREQ / GATE_HZ must be at least 2");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               s3_q, s3_d;
  logic [GW-1:0]      gate_q, gate_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               win_ovf_q, win_ovf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               overflow_q, overflow_d;

  logic               edge_det;
  logic               edge_sat;
  logic [CNT_W-1:0]   edge_cnt_inc;
  logic               win_ovf_now;

  // Synchronizer plus delay flop; runs regardless of FSM state so edges are never stale.
  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign edge_det = s2_q & ~s3_q;

  // Saturating edge-count candidate and the window overflow flag including this cycle.
  always_comb begin
    edge_sat     = &edge_cnt_q;
    edge_cnt_inc = (edge_det && !edge_sat) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
    win_ovf_now  = win_ovf_q | (edge_det & edge_sat);
  end

  // Next-state logic: window sequencing, terminal-cycle reporting and abort.
  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    edge_cnt_d = edge_cnt_q;
    win_ovf_d  = win_ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        gate_d     = '0;
        edge_cnt_d = '0;
        win_ovf_d  = 1'b0;
        if (enable) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (gate_q == GATE_LAST) begin
          // Terminal cycle reports even if enable just dropped; an edge here belongs to this window.
          count_d    = edge_cnt_inc;
          overflow_d = win_ovf_now;
          valid_d    = 1'b1;
          gate_d     = '0;
          edge_cnt_d = '0;
          win_ovf_d  = 1'b0;
          state_d    = enable ? MEASURE : IDLE;
        end else if (!enable) begin
          // Abort: partial window is discarded, last result stays visible.
          gate_d     = '0;
          edge_cnt_d = '0;
          win_ovf_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          gate_d     = gate_q + GW'(1);
          edge_cnt_d = edge_cnt_inc;
          win_ovf_d  = win_ovf_now;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      gate_q     <= '0;
      edge_cnt_q <= '0;
      win_ovf_q  <= 1'b0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      gate_q     <= gate_d;
      edge_cnt_q <= edge_cnt_d;
      win_ovf_q  <= win_ovf_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign busy     = (state_q == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: three instances (GATE_LEN 10, GATE_LEN 10 with 2-bit count, GATE_LEN 20).
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Expected counts are hand-derived from the sig_in vectors and the 2-cycle detection delay.
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in, enable;
  logic        sig_b, en_b;
  logic        sig_c, en_c;
  logic [31:0] count;
  logic        valid, overflow, busy;
  logic [1:0]  count_b;
  logic        valid_b, overflow_b, busy_b;
  logic [31:0] count_c;
  logic        valid_c, overflow_c, busy_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  freq_meter #(.CLK_FREQ(100), .GATE_HZ(10)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
    .count(count), .valid(valid), .overflow(overflow), .busy(busy)
  );

  freq_meter #(.CLK_FREQ(100), .GATE_HZ(10), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_b), .enable(en_b),
    .count(count_b), .valid(valid_b), .overflow(overflow_b), .busy(busy_b)
  );

  freq_meter #(.CLK_FREQ(100), .GATE_HZ(5)) dut_c (
    .clk(clk), .rst(rst), .sig_in(sig_c), .enable(en_c),
    .count(count_c), .valid(valid_c), .overflow(overflow_c), .busy(busy_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int exp_a[7]    = '{2, 3, 2, 3, 0, 0, 0};
  int exp_e[3]    = '{1, 0, 1};
  int exp_b[3]    = '{3, 3, 0};
  int exp_bovf[3] = '{1, 1, 0};

  initial begin
    int sum;
    rst = 1'b1; sig_in = 1'b0; enable = 1'b0;
    sig_b = 1'b0; en_b = 1'b0; sig_c = 1'b0; en_c = 1'b0;
    do_reset();
    check("rst_count", count, 0);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_busy", {31'd0, busy}, 0);

    // Period-4 toggle for 4 windows, then sig_in low for 3 more windows.
    sum = 0;
    for (int n = 0; n <= 70; n++) begin
      sig_in = (n < 40) && ((n / 2) % 2 == 1);
      enable = 1'b1;
      tick();
      check("run_busy", {31'd0, busy}, 1);
      check("run_valid", {31'd0, valid}, {31'd0, (n > 0) && (n % 10 == 0)});
      if (n > 0 && n % 10 == 0) begin
        check("run_count", count, exp_a[n / 10 - 1]);
        check("run_overflow", {31'd0, overflow}, 0);
        if (n <= 40) sum += int'(count);
      end
    end
    check("run_sum4", sum, 10);
    enable = 1'b0; sig_in = 1'b0;
    do_reset();

    // Edge detected on terminal cycle of window 1, then on first cycle of window 3.
    for (int n = 0; n <= 30; n++) begin
      sig_in = (n == 8) || (n == 19);
      enable = 1'b1;
      tick();
      check("term_valid", {31'd0, valid}, {31'd0, (n > 0) && (n % 10 == 0)});
      if (n > 0 && n % 10 == 0) check("term_count", count, exp_e[n / 10 - 1]);
    end
    enable = 1'b0; sig_in = 1'b0;
    do_reset();

    // 2-bit counter saturation and overflow, then a clean window.
    for (int n = 0; n <= 30; n++) begin
      sig_b = (n <= 18) && (n % 2 == 1);
      en_b = 1'b1;
      tick();
      check("sat_valid", {31'd0, valid_b}, {31'd0, (n > 0) && (n % 10 == 0)});
      if (n > 0 && n % 10 == 0) begin
        check("sat_count", {30'd0, count_b}, exp_b[n / 10 - 1]);
        check("sat_overflow", {31'd0, overflow_b}, exp_bovf[n / 10 - 1]);
      end
    end
    en_b = 1'b0; sig_b = 1'b0;
    do_reset();

    // Abort at gate count 5 of window 2; count holds window 1 result.
    for (int n = 0; n <= 22; n++) begin
      sig_in = (n < 16) && ((n / 2) % 2 == 1);
      enable = (n < 16);
      tick();
      check("abort_valid", {31'd0, valid}, {31'd0, n == 10});
      if (n == 10) check("abort_count_w1", count, 2);
      if (n == 15) check("abort_busy_before", {31'd0, busy}, 1);
      if (n == 16) check("abort_busy_after", {31'd0, busy}, 0);
      if (n == 22) begin
        check("abort_count_held", count, 2);
        check("abort_overflow", {31'd0, overflow}, 0);
      end
    end

    // enable dropped on the terminal cycle still reports, then IDLE.
    for (int k = 0; k <= 11; k++) begin
      sig_in = (k == 3) || (k == 4);
      enable = (k < 10);
      tick();
      check("lastdrop_valid", {31'd0, valid}, {31'd0, k == 10});
      if (k == 9) check("lastdrop_busy_in", {31'd0, busy}, 1);
      if (k == 10) begin
        check("lastdrop_count", count, 1);
        check("lastdrop_busy_out", {31'd0, busy}, 0);
      end
      if (k == 11) check("lastdrop_idle", {31'd0, busy}, 0);
    end

    // GATE_LEN 20 instance: 7 edges, then reset mid-window 2.
    for (int n = 0; n <= 25; n++) begin
      en_c = 1'b1;
      sig_c = (n < 14) && (n % 2 == 1);
      if (n == 25) begin
        rst = 1'b1;
        enable = 1'b1;
        sig_in = 1'b1;
      end
      tick();
      if (n == 20) begin
        check("c_valid_w1", {31'd0, valid_c}, 1);
        check("c_count_w1", count_c, 7);
        check("c_overflow_w1", {31'd0, overflow_c}, 0);
      end
      if (n == 22) check("c_count_held", count_c, 7);
    end
    check("midrst_count", count_c, 0);
    check("midrst_valid", {31'd0, valid_c}, 0);
    check("midrst_busy", {31'd0, busy_c}, 0);
    check("midrst_main_count", count, 0);
    check("midrst_main_busy", {31'd0, busy}, 0);

    // After release: sig_in already high counts as one edge; first valid 10 / 20 cycles after entry.
    rst = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      enable = 1'b1;
      en_c = 1'b1;
      sig_in = 1'b1;
      sig_c = 1'b0;
      tick();
      if (k == 0) check("rel_busy", {31'd0, busy}, 1);
      if (k <= 10) check("rel_valid", {31'd0, valid}, {31'd0, k == 10});
      if (k == 10) check("rel_count_high_at_release", count, 1);
      if (k == 19) check("rel_c_valid_early", {31'd0, valid_c}, 0);
      if (k == 20) begin
        check("rel_c_valid", {31'd0, valid_c}, 1);
        check("rel_c_count", count_c, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, is the clk frequency in Hz.
REQ-002 Parameter GATE_HZ, default 1, sets the measurement windows per second; GATE_LEN = CLK_FREQ / GATE_HZ (integer division) clk cycles per window.
REQ-003 Parameter CNT_W, default 32, is the width of the edge count result.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sig_in  input  1  asynchronous signal whose rising edges are counted.
REQ-007 enable  input  1  level; 1 = run back-to-back measurement windows, 0 = stop.
REQ-008 count  output  CNT_W  number of sig_in rising edges in the last completed window.
REQ-009 valid  output  1  one-cycle pulse; count and overflow were updated this cycle.
REQ-010 overflow  output  1  last completed window saturated its edge counter.
REQ-011 busy  output  1  high while a window is in progress.

Function
REQ-012 sig_in shall pass through a 2-flop synchronizer (s1, s2) followed by a delay flop s3; edge = s2 & ~s3.
REQ-013 Synchronizer and delay flops shall run in every state, independent of enable.
REQ-014 The FSM shall have exactly two states: IDLE and MEASURE; busy = (state == MEASURE).
REQ-015 IDLE: gate counter and edge counter held at 0; on enable = 1, go to MEASURE next cycle.
REQ-016 MEASURE: the gate counter (width $clog2(GATE_LEN)) increments by 1 every cycle, starting at 0.
REQ-017 MEASURE: the edge counter increments on each cycle with edge = 1, saturating at 2^CNT_W-1; an increment attempted at saturation sets the window overflow flag.
REQ-018 Terminal cycle (MEASURE, gate counter == GATE_LEN-1), registered next edge: count <= edge counter + edge (saturated), overflow <= window flag (incl. saturation on this cycle), valid <= 1; gate counter, edge counter and window flag cleared.
REQ-019 After the terminal cycle, stay in MEASURE if enable = 1 (next window starts immediately, no dead cycle, period exactly GATE_LEN cycles), else go to IDLE.
REQ-020 An edge on the terminal cycle shall count in the ending window; an edge on the next cycle shall count in the new window.
REQ-021 enable = 0 on a non-terminal MEASURE cycle shall abort the window: go to IDLE, clear counters, no valid; count and overflow keep their previous values.
REQ-022 enable = 0 on the terminal cycle shall still report the window (REQ-018), then go to IDLE.
REQ-023 valid shall be 0 on every cycle not following a terminal cycle.
REQ-024 Pulses narrower than one clk period, or edges spaced under 2 cycles apart, may be missed; at most GATE_LEN/2 edges are countable per window.
REQ-025 GATE_LEN < 2 shall be an elaboration-time error.

Reset
REQ-026 On rst = 1 at a clk edge: state = IDLE; s1, s2, s3, gate counter, edge counter, window flag = 0; count = 0, valid = 0, overflow = 0, busy = 0.
REQ-027 rst shall override enable and any in-progress window; the partial window is discarded without valid.
REQ-028 sig_in high at reset release appears as a rising edge (s3 resets to 0) and is counted if MEASURE is active when detected.

Verification (CLK_FREQ = 100, GATE_HZ = 10 -> GATE_LEN = 10 unless stated)
VER-001 Reset, enable = 1, sig_in toggling every 2 cycles (period 4) -> valid every 10 cycles, count = 2 or 3 per window depending on phase, sum over 4 windows = 10, overflow = 0.
VER-002 sig_in held 0, enable = 1 -> count = 0, valid every 10 cycles; busy stays 1; no cycle gap between windows.
VER-003 Edge arranged to be detected exactly on the terminal cycle, then on the following cycle -> first counted in window N, second in window N+1.
VER-004 CNT_W = 2, sig_in period 2 cycles (5 edges/window) -> count = 3, overflow = 1; following window with sig_in = 0 -> count = 0, overflow = 0.
VER-005 enable dropped at gate count 5 -> no valid, busy = 0 next cycle, count keeps prior value; enable dropped on terminal cycle -> valid pulse, then IDLE.
VER-006 rst asserted mid-window with count = 7 held -> next cycle count = 0, valid = 0, busy = 0; after release and enable = 1, first valid exactly 10 cycles after MEASURE entry.
